// File: rtl/acc_reg_arb.sv
//==============================================================================
// Module      : acc_reg_arb
// Description : Round-robin arbiter that shares the CPU register read and
//               write ports between NUM_REQ accelerator requesters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package acc_pkg;
    typedef logic [7:0]  reg_addr_t;
    typedef logic [31:0] data_t;
endpackage

module acc_reg_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  acc_pkg::reg_addr_t [NUM_REQ-1:0][2:0] req_raddr_i,
    input  logic [NUM_REQ-1:0]                   req_rready_i,
    output acc_pkg::data_t [2:0]                 req_rdata_o,
    output logic [NUM_REQ-1:0]                   req_rvalid_o,
    input  acc_pkg::reg_addr_t [NUM_REQ-1:0]     req_waddr_i,
    input  acc_pkg::data_t [NUM_REQ-1:0]         req_wdata_i,
    input  logic [NUM_REQ-1:0]                   req_wren_i,
    output logic [NUM_REQ-1:0]                   req_wready_o,
    output acc_pkg::reg_addr_t [2:0]             reg_raddr_o,
    output logic                                 reg_rready_o,
    input  acc_pkg::data_t [2:0]                 reg_rdata_i,
    input  logic                                 reg_rvalid_i,
    output acc_pkg::reg_addr_t                   reg_waddr_o,
    output acc_pkg::data_t                       reg_wdata_o,
    output logic                                 reg_wren_o,
    input  logic                                 reg_wready_i,
    output logic                                 busy_o
);

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [PTR_W-1:0] c_last = PTR_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t r_rstate, w_rstate_nxt, r_wstate, w_wstate_nxt;

    logic [PTR_W-1:0] r_rptr, r_rgnt, w_rsel;
    logic [PTR_W-1:0] r_wptr, r_wgnt, w_wsel;
    logic             w_rdone, w_wdone;

    acc_pkg::reg_addr_t [2:0] r_raddr;
    acc_pkg::reg_addr_t       r_waddr;
    acc_pkg::data_t           r_wdata;

    // Rotate the request vector so the pointer sits at bit 0, then take the
    // first set bit and map it back to an absolute requester index.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr);
        logic [2*NUM_REQ-1:0] v_rot;
        logic [PTR_W:0]       v_idx;
        logic [PTR_W-1:0]     v_pick;
        logic                 v_found;
        v_rot   = {req, req} >> ptr;
        v_pick  = '0;
        v_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (v_idx >= (PTR_W+1)'(NUM_REQ))
                v_idx = v_idx - (PTR_W+1)'(NUM_REQ);
            if (!v_found && v_rot[i]) begin
                v_pick  = v_idx[PTR_W-1:0];
                v_found = 1'b1;
            end
        end
        return v_pick;
    endfunction

    assign w_rsel = rr_pick(req_rready_i, r_rptr);
    assign w_wsel = rr_pick(req_wren_i, r_wptr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rstate <= ST_IDLE;
            r_wstate <= ST_IDLE;
            r_rptr   <= '0;
            r_wptr   <= '0;
            r_rgnt   <= '0;
            r_wgnt   <= '0;
            r_raddr  <= '0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_wstate <= w_wstate_nxt;
            if (r_rstate == ST_IDLE && |req_rready_i) begin
                r_rgnt  <= w_rsel;
                r_raddr <= req_raddr_i[w_rsel];
            end
            if (r_wstate == ST_IDLE && |req_wren_i) begin
                r_wgnt  <= w_wsel;
                r_waddr <= req_waddr_i[w_wsel];
                r_wdata <= req_wdata_i[w_wsel];
            end
            if (w_rdone)
                r_rptr <= (r_rgnt == c_last) ? '0 : r_rgnt + 1'b1;
            if (w_wdone)
                r_wptr <= (r_wgnt == c_last) ? '0 : r_wgnt + 1'b1;
        end
    end

    // Next-state and outputs; reset masks every output combinationally so a
    // completion arriving in the reset cycle produces no strobe.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_wstate_nxt = r_wstate;
        w_rdone      = 1'b0;
        w_wdone      = 1'b0;
        case (r_rstate)
            ST_IDLE: if (|req_rready_i) w_rstate_nxt = ST_BUSY;
            ST_BUSY: if (reg_rvalid_i) begin
                w_rstate_nxt = ST_IDLE;
                w_rdone      = !rst_i;
            end
            default: w_rstate_nxt = ST_IDLE;
        endcase
        case (r_wstate)
            ST_IDLE: if (|req_wren_i) w_wstate_nxt = ST_BUSY;
            ST_BUSY: if (reg_wready_i) begin
                w_wstate_nxt = ST_IDLE;
                w_wdone      = !rst_i;
            end
            default: w_wstate_nxt = ST_IDLE;
        endcase

        req_rvalid_o = w_rdone ? (NUM_REQ'(1) << r_rgnt) : '0;
        req_wready_o = w_wdone ? (NUM_REQ'(1) << r_wgnt) : '0;
        req_rdata_o  = w_rdone ? reg_rdata_i : '0;
        reg_rready_o = (r_rstate == ST_BUSY) && !rst_i;
        reg_wren_o   = (r_wstate == ST_BUSY) && !rst_i;
        reg_raddr_o  = rst_i ? '0 : r_raddr;
        reg_waddr_o  = rst_i ? '0 : r_waddr;
        reg_wdata_o  = rst_i ? '0 : r_wdata;
        busy_o       = (r_rstate == ST_BUSY || r_wstate == ST_BUSY) && !rst_i;
    end

endmodule

`default_nettype wire
